// File: rtl/tbcm_crc_pkg.sv
// Shared CRC types, polynomials and update-matrix helpers for tbcm links.
// Polynomials omit the x^W term; all CRCs are zero-init, unreflected.
package tbcm_crc_pkg;

  typedef enum logic [1:0] {
    TBCM_CRC_8,
    TBCM_CRC_16,
    TBCM_CRC_32
  } tbcm_crc_type;

  localparam int TBCM_CRC_MAXW = 128;
  localparam int TBCM_CRC_LENGTH_WIDTH = 16;

  typedef struct packed {
    logic                             error;
    logic                             short;
    logic [TBCM_CRC_LENGTH_WIDTH-1:0] length;
  } tbcm_crc_status;

  function automatic int get_crc_width(
    input tbcm_crc_type t
  );
    case (t)
      TBCM_CRC_8:  return 8;
      TBCM_CRC_16: return 16;
      default:     return 32;
    endcase
  endfunction

  function automatic logic [63:0] get_crc_polynomial(
    input tbcm_crc_type t
  );
    case (t)
      TBCM_CRC_8:  return 64'h07;
      TBCM_CRC_16: return 64'h1021;
      default:     return 64'h04C1_1DB7;
    endcase
  endfunction

  // Bit-serial MSB-first division; used only at elaboration.
  function automatic logic [TBCM_CRC_MAXW-1:0] crc_step(
    input logic [TBCM_CRC_MAXW-1:0] poly,
    input int                       cw,
    input int                       dw,
    input logic [TBCM_CRC_MAXW-1:0] res,
    input logic [TBCM_CRC_MAXW-1:0] data
  );
    logic [TBCM_CRC_MAXW-1:0] r;
    logic                     fb;
    r = res;
    for (int b = dw - 1; b >= 0; b--) begin
      fb = r[cw-1] ^ data[b];
      r  = r << 1;
      if (fb) r = r ^ poly;
    end
    return r & ({TBCM_CRC_MAXW{1'b1}} >> (TBCM_CRC_MAXW - cw));
  endfunction

  // Row `row` of DMAT (data_sel=1) or SMAT (data_sel=0): bit i is the
  // contribution of input bit i to residue_next[row].
  function automatic logic [TBCM_CRC_MAXW-1:0] get_crc_update_matrix(
    input logic [TBCM_CRC_MAXW-1:0] poly,
    input int                       cw,
    input int                       dw,
    input logic                     data_sel,
    input int                       row
  );
    logic [TBCM_CRC_MAXW-1:0] m;
    logic [TBCM_CRC_MAXW-1:0] unit;
    logic [TBCM_CRC_MAXW-1:0] col;
    m = '0;
    for (int i = 0; i < (data_sel ? dw : cw); i++) begin
      unit = TBCM_CRC_MAXW'(1) << i;
      if (data_sel) col = crc_step(poly, cw, dw, '0, unit);
      else          col = crc_step(poly, cw, dw, unit, '0);
      m[i] = col[row];
    end
    return m;
  endfunction

endpackage

// File: rtl/tbcm_crc_update.sv
// One-beat parallel CRC update: residue*x^D ^ data*x^W mod P.
// Ports: i_residue, i_data in; o_residue_next out. Purely combinational.
module tbcm_crc_update
  import tbcm_crc_pkg::*;
#(
  parameter int                   DATA_WIDTH     = 8,
  parameter int                   CRC_WIDTH      = 32,
  parameter logic [CRC_WIDTH-1:0] CRC_POLYNOMIAL = CRC_WIDTH'(32'h04C1_1DB7)
) (
  input  logic [CRC_WIDTH-1:0]  i_residue,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [CRC_WIDTH-1:0]  o_residue_next
);

  localparam logic [TBCM_CRC_MAXW-1:0] POLY =
    TBCM_CRC_MAXW'(CRC_POLYNOMIAL);

  for (genvar j = 0; j < CRC_WIDTH; j++) begin : g_row
    localparam logic [TBCM_CRC_MAXW-1:0] DROW =
      get_crc_update_matrix(POLY, CRC_WIDTH, DATA_WIDTH, 1'b1, j);
    localparam logic [TBCM_CRC_MAXW-1:0] SROW =
      get_crc_update_matrix(POLY, CRC_WIDTH, DATA_WIDTH, 1'b0, j);
    assign o_residue_next[j] =
      (^(i_data & DROW[DATA_WIDTH-1:0])) ^
      (^(i_residue & SROW[CRC_WIDTH-1:0]));
  end

endmodule

// File: rtl/tbcm_crc_checker.sv
// Streaming CRC checker: divides each packet (CRC in the final beats) and
// reports error/short/length once per packet on a valid/ready status port.
module tbcm_crc_checker
  import tbcm_crc_pkg::*;
#(
  parameter int                   DATA_WIDTH     = 8,
  parameter tbcm_crc_type         CRC_TYPE       = TBCM_CRC_32,
  parameter int                   CRC_WIDTH      = get_crc_width(CRC_TYPE),
  parameter logic [CRC_WIDTH-1:0] CRC_POLYNOMIAL =
    CRC_WIDTH'(get_crc_polynomial(CRC_TYPE)),
  parameter int                   LENGTH_WIDTH   = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [DATA_WIDTH-1:0]   i_data,
  input  logic                    i_last,
  output logic                    o_status_valid,
  input  logic                    i_status_ready,
  output logic                    o_status_error,
  output logic                    o_status_short,
  output logic [LENGTH_WIDTH-1:0] o_status_length
);

  if (CRC_WIDTH % DATA_WIDTH != 0) begin : g_bad_width
    $fatal(1, "CRC_WIDTH must be a multiple of DATA_WIDTH");
  end

  localparam int MIN_BEATS = CRC_WIDTH / DATA_WIDTH;

  typedef enum logic [0:0] {
    ST_ACTIVE = 1'b0,
    ST_STATUS = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [CRC_WIDTH-1:0]    r_residue;
  logic [CRC_WIDTH-1:0]    w_residue_next;
  logic [LENGTH_WIDTH-1:0] r_count;
  logic [LENGTH_WIDTH-1:0] w_count_next;
  logic                    r_err;
  logic                    r_short;
  logic [LENGTH_WIDTH-1:0] r_len;
  logic                    w_accept;
  logic                    w_short;

  tbcm_crc_update #(
    .DATA_WIDTH     (DATA_WIDTH),
    .CRC_WIDTH      (CRC_WIDTH),
    .CRC_POLYNOMIAL (CRC_POLYNOMIAL)
  ) u_update (
    .i_residue      (r_residue),
    .i_data         (i_data),
    .o_residue_next (w_residue_next)
  );

  assign o_ready  = (r_state == ST_ACTIVE);
  assign w_accept = i_valid & o_ready;

  assign w_count_next = (r_count == '1) ? r_count
                                        : r_count + 1'b1;
  assign w_short = (w_count_next < LENGTH_WIDTH'(MIN_BEATS));

  assign o_status_valid  = (r_state == ST_STATUS);
  assign o_status_error  = r_err;
  assign o_status_short  = r_short;
  assign o_status_length = r_len;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_ACTIVE:
        if (w_accept && i_last) w_state_next = ST_STATUS;
      ST_STATUS:
        if (i_status_ready) w_state_next = ST_ACTIVE;
      default:
        w_state_next = ST_ACTIVE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_ACTIVE;
      r_residue <= '0;
      r_count   <= '0;
      r_err     <= 1'b0;
      r_short   <= 1'b0;
      r_len     <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        if (i_last) begin
          r_residue <= '0;
          r_count   <= '0;
          r_err     <= (|w_residue_next) | w_short;
          r_short   <= w_short;
          r_len     <= w_count_next;
        end else begin
          r_residue <= w_residue_next;
          r_count   <= w_count_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_tbcm_crc_checker.sv
// Scoreboard bench for tbcm_crc_checker (CRC-32, 8-bit beats), with a
// second 4-bit-length instance sharing stimulus for saturation.
module tb_tbcm_crc_checker;
  import tbcm_crc_pkg::*;

  logic        clk;
  logic        i_rst;
  logic        i_valid;
  logic [7:0]  i_data;
  logic        i_last;
  logic        i_status_ready;

  logic        o_ready;
  logic        o_status_valid;
  logic        o_status_error;
  logic        o_status_short;
  logic [15:0] o_status_length;

  logic        s_ready;
  logic        s_status_valid;
  logic        s_status_error;
  logic        s_status_short;
  logic [3:0]  s_status_length;

  tbcm_crc_checker u_dut (
    .i_clk           (clk),
    .i_rst           (i_rst),
    .i_valid         (i_valid),
    .o_ready         (o_ready),
    .i_data          (i_data),
    .i_last          (i_last),
    .o_status_valid  (o_status_valid),
    .i_status_ready  (i_status_ready),
    .o_status_error  (o_status_error),
    .o_status_short  (o_status_short),
    .o_status_length (o_status_length)
  );

  tbcm_crc_checker #(
    .LENGTH_WIDTH (4)
  ) u_sat (
    .i_clk           (clk),
    .i_rst           (i_rst),
    .i_valid         (i_valid),
    .o_ready         (s_ready),
    .i_data          (i_data),
    .i_last          (i_last),
    .o_status_valid  (s_status_valid),
    .i_status_ready  (i_status_ready),
    .o_status_error  (s_status_error),
    .o_status_short  (s_status_short),
    .o_status_length (s_status_length)
  );

  typedef struct {
    logic err;
    logic sht;
    int   len;
  } exp_t;

  exp_t        q_main[$];
  exp_t        q_sat[$];
  int          n_chk;
  int          n_pass;
  int          n_status;
  logic [31:0] m_res;
  int          m_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(
    input string       tag,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s got=%0h want=%0h", tag, act, exp);
  endtask

  function automatic logic [31:0] crc_byte(
    input logic [31:0] r,
    input logic [7:0]  d
  );
    logic [31:0] x;
    logic        fb;
    x = r;
    for (int b = 7; b >= 0; b--) begin
      fb = x[31] ^ d[b];
      x  = {x[30:0], 1'b0};
      if (fb) x = x ^ 32'h04C1_1DB7;
    end
    return x;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    exp_t e;
    logic acc;
    m_res = crc_byte(m_res, d);
    m_cnt++;
    if (last) begin
      e.sht = (m_cnt < 4);
      e.err = (m_res != 0) || e.sht;
      e.len = (m_cnt > 65535) ? 65535 : m_cnt;
      q_main.push_back(e);
      e.len = (m_cnt > 15) ? 15 : m_cnt;
      q_sat.push_back(e);
      m_res = '0;
      m_cnt = 0;
    end
    i_valid = 1'b1;
    i_data  = d;
    i_last  = last;
    acc     = 1'b0;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      if (o_ready) acc = 1'b1;
      @(posedge clk);
      #1;
    end
    check("accept", {31'd0, acc}, 32'd1);
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic send_good(input int max_gap);
    logic [7:0] pkt [5];
    pkt[0] = 8'h01;
    pkt[1] = 8'h04;
    pkt[2] = 8'hC1;
    pkt[3] = 8'h1D;
    pkt[4] = 8'hB7;
    for (int i = 0; i < 5; i++) begin
      if (max_gap > 0) idle($urandom_range(0, max_gap));
      send(pkt[i], i == 4);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!i_rst && o_status_valid && i_status_ready) begin
      n_status++;
      if (q_main.size() == 0) begin
        check("main_unexpected", 32'd1, 32'd0);
      end else begin
        e = q_main.pop_front();
        check("main_err", {31'd0, o_status_error}, {31'd0, e.err});
        check("main_short", {31'd0, o_status_short}, {31'd0, e.sht});
        check("main_len", {16'd0, o_status_length}, e.len);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!i_rst && s_status_valid && i_status_ready) begin
      if (q_sat.size() == 0) begin
        check("sat_unexpected", 32'd1, 32'd0);
      end else begin
        e = q_sat.pop_front();
        check("sat_err", {31'd0, s_status_error}, {31'd0, e.err});
        check("sat_short", {31'd0, s_status_short}, {31'd0, e.sht});
        check("sat_len", {28'd0, s_status_length}, e.len);
      end
    end
  end

  initial begin
    int base;
    n_chk          = 0;
    n_pass         = 0;
    n_status       = 0;
    m_res          = '0;
    m_cnt          = 0;
    i_rst          = 1'b1;
    i_valid        = 1'b0;
    i_data         = '0;
    i_last         = 1'b0;
    i_status_ready = 1'b1;
    idle(2);
    check("rst_ready", {31'd0, o_ready}, 32'd1);
    check("rst_svalid", {31'd0, o_status_valid}, 32'd0);
    check("rst_err", {31'd0, o_status_error}, 32'd0);
    check("rst_short", {31'd0, o_status_short}, 32'd0);
    check("rst_len", {16'd0, o_status_length}, 32'd0);
    check("rst_sat_ready", {31'd0, s_ready}, 32'd1);
    i_rst = 1'b0;
    idle(1);

    send_good(0);
    check("latency", {31'd0, o_status_valid}, 32'd1);
    idle(2);

    send(8'h01, 1'b0);
    send(8'h04, 1'b0);
    send(8'hC1, 1'b0);
    send(8'h1D, 1'b0);
    send(8'hB6, 1'b1);
    idle(2);

    send(8'hAA, 1'b1);
    idle(2);

    i_status_ready = 1'b0;
    send_good(0);
    repeat (10) begin
      @(negedge clk);
      check("bp_ready", {31'd0, o_ready}, 32'd0);
      check("bp_valid", {31'd0, o_status_valid}, 32'd1);
      check("bp_err", {31'd0, o_status_error}, 32'd0);
      check("bp_len", {16'd0, o_status_length}, 32'd5);
    end
    @(posedge clk);
    #1;
    i_status_ready = 1'b1;
    idle(1);
    check("post_ready", {31'd0, o_ready}, 32'd1);
    check("post_valid", {31'd0, o_status_valid}, 32'd0);
    check("post_len_hold", {16'd0, o_status_length}, 32'd5);
    for (int i = 0; i < 5; i++) send(8'h00, i == 4);
    idle(2);

    send(8'h12, 1'b0);
    send(8'h34, 1'b0);
    i_rst = 1'b1;
    idle(1);
    i_rst = 1'b0;
    m_res = '0;
    m_cnt = 0;
    base  = n_status;
    send_good(3);
    idle(3);
    check("one_status", n_status - base, 32'd1);

    for (int i = 0; i < 20; i++) send(8'h00, i == 19);
    idle(5);

    check("q_main_empty", q_main.size(), 32'd0);
    check("q_sat_empty", q_sat.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
